// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
// Serial configuration loader for an array of CLBs. A bitstream arrives one
// bit per DEN-qualified cycle, MSB first:
//   sync pattern 0010 (any leading 1s) | N (NFRM_W bits) | N frames
// Each frame carries 37 configuration bits (plus one even-parity bit when
// CFG_PARITY_EN is defined). Every frame is written to the target through a
// CFG_WE/CFG_RDY handshake at CFG_ADDR = 0 .. N-1.
//
// Optional feature macro: CFG_PARITY_EN (38-bit frames, even parity checked).
//
// Ports:
//   K        in   clock, rising edge
//   RSTN     in   asynchronous active-low reset
//   DIN      in   serial bitstream, MSB first
//   DEN      in   DIN valid this cycle
//   CFG_RDY  in   target accepts a word
//   CFG_WE   out  configuration write strobe
//   CFG_ADDR out  target CLB index (NFRM_W bits)
//   CFG_DATA out  37-bit frame: mem[15:0], comboption[1:0], mux2..6select,
//                 o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1, DQmux1,
//                 DQmux2, floporlatch
//   BUSY     out  source must hold DEN low (WRITE, DONE, ERROR)
//   DONE     out  all frames written (sticky until reset)
//   ERR      out  parity or overrun error (sticky until reset)
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int NFRM_W = 8
) (
    input  logic              K,
    input  logic              RSTN,
    input  logic              DIN,
    input  logic              DEN,
    input  logic              CFG_RDY,
    output logic              CFG_WE,
    output logic [NFRM_W-1:0] CFG_ADDR,
    output logic [36:0]       CFG_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

`ifdef CFG_PARITY_EN
    localparam int FLEN = 38;
`else
    localparam int FLEN = 37;
`endif
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(NFRM_W - 1);
    localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FLEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FRAME = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

`ifdef CFG_PARITY_EN
    // Even parity over the whole 38-bit frame: XOR of all bits must be zero.
    function automatic logic even_parity_ok(input logic [37:0] f);
        even_parity_ok = ~(^f);
    endfunction
`endif

    state_t              state_r;
    logic [3:0]          win_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [NFRM_W-1:0]   nfrm_r;
    logic [FLEN-2:0]     shift_r;   // earlier bits of the current frame
    logic [NFRM_W-1:0]   addr_r;
    logic [36:0]         data_r;
    logic                we_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic [3:0]          win_next_s;
    logic [NFRM_W-1:0]   hdr_next_s;
    logic [FLEN-1:0]     frame_s;
    logic [36:0]         frame_data_s;
    logic [NFRM_W-1:0]   addr_inc_s;

    // Next-value views of the shift structures including the current DIN bit.
    always_comb begin
        win_next_s = {win_r[2:0], DIN};
        hdr_next_s = {nfrm_r[NFRM_W-2:0], DIN};
        frame_s    = {shift_r, DIN};
`ifdef CFG_PARITY_EN
        frame_data_s = frame_s[37:1];
`else
        frame_data_s = frame_s;
`endif
        addr_inc_s = addr_r + {{(NFRM_W-1){1'b0}}, 1'b1};
    end

    // Loader state machine with registered outputs.
    always_ff @(posedge K or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
            win_r   <= 4'b0000;
            cnt_r   <= {CNT_W{1'b0}};
            nfrm_r  <= {NFRM_W{1'b0}};
            shift_r <= {(FLEN-1){1'b0}};
            addr_r  <= {NFRM_W{1'b0}};
            data_r  <= 37'd0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (DEN) begin
                        win_r <= win_next_s;
                        if (win_next_s == 4'b0010) begin
                            state_r <= ST_HDR;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                end
                ST_HDR: begin
                    if (DEN) begin
                        nfrm_r <= hdr_next_s;
                        cnt_r  <= cnt_r + 8'd1;
                        if (cnt_r == HDR_LAST) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (hdr_next_s == {NFRM_W{1'b0}}) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= ST_FRAME;
                                addr_r  <= {NFRM_W{1'b0}};
                            end
                        end
                    end
                end
                ST_FRAME: begin
                    if (DEN) begin
                        shift_r <= frame_s[FLEN-2:0];
                        cnt_r   <= cnt_r + 8'd1;
                        if (cnt_r == FRM_LAST) begin
                            cnt_r <= {CNT_W{1'b0}};
`ifdef CFG_PARITY_EN
                            if (!even_parity_ok(frame_s)) begin
                                state_r <= ST_ERROR;
                                err_r   <= 1'b1;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= ST_WRITE;
                                data_r  <= frame_data_s;
                                we_r    <= 1'b1;
                                busy_r  <= 1'b1;
                            end
`else
                            state_r <= ST_WRITE;
                            data_r  <= frame_data_s;
                            we_r    <= 1'b1;
                            busy_r  <= 1'b1;
`endif
                        end
                    end
                end
                ST_WRITE: begin
                    // Overrun wins over a coincident handshake in the state
                    // machine: the frame is abandoned and the loader locks up.
                    if (DEN) begin
                        state_r <= ST_ERROR;
                        we_r    <= 1'b0;
                        err_r   <= 1'b1;
                    end else if (CFG_RDY) begin
                        we_r   <= 1'b0;
                        addr_r <= addr_inc_s;
                        if (addr_inc_s == nfrm_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FRAME;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign CFG_WE   = we_r;
    assign CFG_ADDR = addr_r;
    assign CFG_DATA = data_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign ERR      = err_r;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
// Directed-plus-random bench for clb_cfg_loader. The reference model is the
// list of frames the bench sends: frame i must appear as exactly one write at
// address i. A negedge monitor records every CFG_WE&CFG_RDY handshake.
// -----------------------------------------------------------------------------
module tb_clb_cfg_loader;

    localparam int NW = 8;

    logic          K = 1'b0;
    logic          RSTN;
    logic          DIN;
    logic          DEN;
    logic          CFG_RDY;
    logic          CFG_WE;
    logic [NW-1:0] CFG_ADDR;
    logic [36:0]   CFG_DATA;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];

    clb_cfg_loader #(.NFRM_W(NW)) dut (
        .K(K), .RSTN(RSTN), .DIN(DIN), .DEN(DEN), .CFG_RDY(CFG_RDY),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 K = ~K;

    // Handshake monitor, sampled on the inactive edge.
    always @(negedge K) begin
        if (RSTN === 1'b1 && CFG_WE === 1'b1 && CFG_RDY === 1'b1)
            obs_q.push_back({19'd0, CFG_ADDR, CFG_DATA});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge K);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0; DEN = 1'b0; DIN = 1'b0; CFG_RDY = 1'b1;
        tick(); tick();
        obs_q.delete(); exp_q.delete();
        RSTN = 1'b1;
        tick();
    endtask

    // One valid bit, preceded by a random number of DEN-low gap cycles.
    task automatic send_bit(input logic b, input int gap);
        while ($urandom_range(0, 99) < gap) begin
            DEN = 1'b0; DIN = 1'($urandom_range(0, 1));
            tick();
        end
        DEN = 1'b1; DIN = b;
        tick();
        DEN = 1'b0;
    endtask

    task automatic send_sync_hdr(input int n, input int gap);
        logic [7:0]    sync;
        logic [NW-1:0] nv;
        sync = 8'b1111_0010;
        nv = NW'(n);
        for (int i = 7; i >= 0; i--) send_bit(sync[i], gap);
        for (int i = NW - 1; i >= 0; i--) send_bit(nv[i], gap);
    endtask

    // Sends d ^ flip as data; parity (when present) is computed from d.
    task automatic send_frame(input logic [36:0] d, input logic [36:0] flip, input int gap);
        logic [36:0] tx;
        tx = d ^ flip;
        for (int i = 36; i >= 0; i--) send_bit(tx[i], gap);
`ifdef CFG_PARITY_EN
        send_bit(^d, gap);
`endif
    endtask

    task automatic wait_we_low(input string tag, input bit rand_rdy);
        int n;
        n = 0;
        while (CFG_WE === 1'b1 && n < 60) begin
            if (rand_rdy) CFG_RDY = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        CFG_RDY = 1'b1;
        check(tag, 64'(n < 60), 64'd1);
    endtask

    task automatic check_writes(input string tag);
        int m;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check({tag, "_write"}, obs_q[i], exp_q[i]);
    endtask

    function automatic logic [36:0] rnd37();
        return {5'($urandom()), 32'($urandom())};
    endfunction

    function automatic logic [63:0] wr(input int a, input logic [36:0] d);
        return {19'd0, NW'(a), d};
    endfunction

    initial begin
        logic [36:0] d;
        logic [36:0] fr[3];
        int n;

        // Reset values while RSTN is held low
        RSTN = 1'b0; DEN = 1'b0; DIN = 1'b0; CFG_RDY = 1'b1;
        tick(); tick();
        check("rst_we", CFG_WE, 64'd0);
        check("rst_addr", CFG_ADDR, 64'd0);
        check("rst_data", CFG_DATA, 64'd0);
        check("rst_busy", BUSY, 64'd0);
        check("rst_done", DONE, 64'd0);
        check("rst_err", ERR, 64'd0);
        RSTN = 1'b1;
        tick();

        // Single frame, mem=0x0116, target always ready
        send_sync_hdr(1, 0);
        d = {16'h0116, 21'd0};
        exp_q.push_back(wr(0, d));
        send_frame(d, 37'd0, 0);
        check("a_we", CFG_WE, 64'd1);
        check("a_addr", CFG_ADDR, 64'd0);
        check("a_mem", CFG_DATA[36:21], 64'h0116);
        check("a_busy_wr", BUSY, 64'd1);
        wait_we_low("a_wait", 1'b0);
        check("a_done", DONE, 64'd1);
        check("a_busy", BUSY, 64'd1);
        check("a_err", ERR, 64'd0);
        check_writes("a");

        // Three frames, target stalls five cycles on frame 1, DEN gaps
        do_reset();
        for (int i = 0; i < 3; i++) fr[i] = rnd37();
        send_sync_hdr(3, 20);
        for (int i = 0; i < 3; i++) exp_q.push_back(wr(i, fr[i]));
        send_frame(fr[0], 37'd0, 20);
        wait_we_low("b_wait0", 1'b0);
        check("b_done0", DONE, 64'd0);
        check("b_busy0", BUSY, 64'd0);
        CFG_RDY = 1'b0;
        send_frame(fr[1], 37'd0, 20);
        for (int i = 0; i < 5; i++) begin
            check("b_stall_we", CFG_WE, 64'd1);
            check("b_stall_addr", CFG_ADDR, 64'd1);
            check("b_stall_data", CFG_DATA, 64'(fr[1]));
            tick();
        end
        CFG_RDY = 1'b1;
        wait_we_low("b_wait1", 1'b0);
        check("b_done1", DONE, 64'd0);
        send_frame(fr[2], 37'd0, 20);
        wait_we_low("b_wait2", 1'b0);
        check("b_done2", DONE, 64'd1);
        check_writes("b");

        // Overrun: DEN high during a stalled write
        do_reset();
        send_sync_hdr(2, 10);
        CFG_RDY = 1'b0;
        send_frame(rnd37(), 37'd0, 10);
        check("c_we_pre", CFG_WE, 64'd1);
        DEN = 1'b1; DIN = 1'b1;
        tick();
        DEN = 1'b0;
        check("c_err", ERR, 64'd1);
        check("c_we", CFG_WE, 64'd0);
        check("c_busy", BUSY, 64'd1);
        check("c_done", DONE, 64'd0);
        CFG_RDY = 1'b1;
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 0);
        check("c_err_sticky", ERR, 64'd1);
        check("c_done_sticky", DONE, 64'd0);
        check_writes("c");

        // Reset mid-frame (bit 20 of frame 1), then a fresh stream
        do_reset();
        fr[0] = rnd37() | 37'd1;
        send_sync_hdr(2, 0);
        send_frame(fr[0], 37'd0, 0);
        wait_we_low("d_wait0", 1'b0);
        for (int i = 36; i > 16; i--) send_bit(1'($urandom_range(0, 1)), 0);
        RSTN = 1'b0;
        #2;
        check("d_rst_we", CFG_WE, 64'd0);
        check("d_rst_addr", CFG_ADDR, 64'd0);
        check("d_rst_data", CFG_DATA, 64'd0);
        check("d_rst_busy", BUSY, 64'd0);
        check("d_rst_done", DONE, 64'd0);
        check("d_rst_err", ERR, 64'd0);
        tick();
        obs_q.delete(); exp_q.delete();
        RSTN = 1'b1;
        tick();
        send_sync_hdr(2, 10);
        for (int i = 0; i < 2; i++) begin
            d = rnd37();
            exp_q.push_back(wr(i, d));
            send_frame(d, 37'd0, 10);
            wait_we_low("d_wait", 1'b0);
        end
        check("d_done", DONE, 64'd1);
        check_writes("d");

        // Header N=0 with heavy DEN gaps
        do_reset();
        send_sync_hdr(0, 60);
        check("e_done", DONE, 64'd1);
        check("e_busy", BUSY, 64'd1);
        check("e_err", ERR, 64'd0);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 0);
        check("e_done_sticky", DONE, 64'd1);
        check_writes("e");

`ifdef CFG_PARITY_EN
        // Parity error: one data bit flipped in frame 0
        do_reset();
        send_sync_hdr(2, 10);
        send_frame(rnd37(), 37'd1 << $urandom_range(0, 36), 10);
        check("f_err", ERR, 64'd1);
        check("f_we", CFG_WE, 64'd0);
        check("f_busy", BUSY, 64'd1);
        for (int i = 0; i < 45; i++) send_bit(1'($urandom_range(0, 1)), 0);
        check("f_err_sticky", ERR, 64'd1);
        check("f_done", DONE, 64'd0);
        check_writes("f");
`endif

        // Randomized streams with random target stalls
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n = $urandom_range(1, 5);
            send_sync_hdr(n, 15);
            for (int i = 0; i < n; i++) begin
                d = rnd37();
                exp_q.push_back(wr(i, d));
                send_frame(d, 37'd0, 15);
                wait_we_low("g_wait", 1'b1);
            end
            check("g_done", DONE, 64'd1);
            check("g_err", ERR, 64'd0);
            check_writes("g");
        end

        // Largest frame count: address reaches 2^NW-1 without wrapping
        do_reset();
        n = (1 << NW) - 1;
        send_sync_hdr(n, 0);
        for (int i = 0; i < n; i++) begin
            d = rnd37();
            exp_q.push_back(wr(i, d));
            send_frame(d, 37'd0, 0);
            wait_we_low("h_wait", 1'b0);
        end
        check("h_done", DONE, 64'd1);
        check("h_addr", CFG_ADDR, 64'(n));
        check_writes("h");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
